expr_emitter: RTL



---
 rtl/expr_emitter_pkg.sv | 27 ++
 rtl/expr_emitter_validate.sv | 23 ++
 rtl/expr_emitter.sv | 89 ++++++++
 3 files changed

// File: rtl/expr_emitter_pkg.sv
// expr_emitter_pkg: ASCII codes, FSM and operator encodings shared by the emitter
package expr_emitter_pkg;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_PLUS = 8'h2B;
    localparam logic [7:0] CH_MUL  = 8'h2A;
    localparam logic [3:0] BCD_MAX = 4'd9;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIGIT = 2'd1,
        OP    = 2'd2,
        FIN   = 2'd3
    } state_t;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return CH_ZERO + {4'h0, d};
    endfunction

    function automatic logic [7:0] op_char(input logic o);
        return (o == OP_MUL) ? CH_MUL : CH_PLUS;
    endfunction

endpackage

// File: rtl/expr_emitter_validate.sv
// expr_validate: combinational legality check of an operand count and its BCD terms
module expr_validate
    import expr_emitter_pkg::*;
#(
    parameter int MAX_TERMS = 8
) (
    input  logic [$clog2(MAX_TERMS+1)-1:0] len,
    input  logic [4*MAX_TERMS-1:0]         digits,
    output logic                           ok
);

    logic bad_digit;

    // flag any in-use term whose nibble is not a decimal digit; terms past len are don't-care
    always_comb begin
        bad_digit = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++)
            if (i < int'(len) && digits[4*i +: 4] > BCD_MAX) bad_digit = 1'b1;
    end

    assign ok = (int'(len) != 0) && (int'(len) <= MAX_TERMS) && !bad_digit;

endmodule

// File: rtl/expr_emitter.sv
// expr_emitter: serialises a latched digit/operator list into an ASCII byte stream
module expr_emitter
    import expr_emitter_pkg::*;
#(
    parameter int MAX_TERMS = 8
) (
    input  logic                           clk,
    input  logic                           clr_n,
    input  logic                           start,
    input  logic [$clog2(MAX_TERMS+1)-1:0] len,
    input  logic [4*MAX_TERMS-1:0]         digits,
    input  logic [MAX_TERMS-2:0]           ops,
    output logic [7:0]                     out_char,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           done,
    output logic                           err
);

    localparam int LW = $clog2(MAX_TERMS+1);
    localparam int IW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic [LW-1:0]          len_q;
    logic [4*MAX_TERMS-1:0] dig_q;
    logic [MAX_TERMS-2:0]   ops_q;
    logic                   ok;
    logic                   last;

    expr_validate #(.MAX_TERMS(MAX_TERMS)) u_validate (
        .len    (len),
        .digits (digits),
        .ok     (ok)
    );

    assign last = (idx == IW'(len_q - 1'b1));

    // emitter FSM; FIN also samples start so a request in the done cycle is taken
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state     <= IDLE;
            idx       <= '0;
            out_char  <= 8'h00;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE, FIN: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start && ok) begin
                        state     <= DIGIT;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_char  <= digit_char(digits[3:0]);
                        idx       <= '0;
                        len_q     <= len;
                        dig_q     <= digits;
                        ops_q     <= ops;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                DIGIT: if (out_ready) begin
                    if (last) begin
                        state     <= FIN;
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        state    <= OP;
                        out_char <= op_char(ops_q[idx]);
                    end
                end
                OP: if (out_ready) begin
                    state    <= DIGIT;
                    idx      <= idx + 1'b1;
                    out_char <= digit_char(dig_q[4*(int'(idx)+1) +: 4]);
                end
            endcase
        end
    end

endmodule
